// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data memory bus initiators: bus widths, read
// latency default and the region-reader state encoding.
package mem_bus_pkg;

  localparam int WORD_BYTES      = 4;
  localparam int MEM_ADDR_W      = 32;
  localparam int MEM_DATA_W      = 32;
  localparam int MEM_WAIT_CYCLES = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  // Counter width able to hold cycles-1, never narrower than one bit.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that paces the memory read latency. Load presets
// WAIT_CYCLES-1; expire is high while the count sits at zero.
module mem_wait_timer
  import mem_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int TW = timer_width(WAIT_CYCLES);

  logic [TW-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TW'(WAIT_CYCLES - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/mem_region_reader.sv
// Walks a contiguous word region on the slow data memory bus and streams each
// captured word out on a valid/ready port, tagged with its 0-based index.
module mem_region_reader
  import mem_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES,
  parameter int CNT_W       = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]      word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [MEM_DATA_W-1:0] mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MEM_DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]      out_index
);

  localparam logic [MEM_ADDR_W-1:0] ALIGN_MASK = MEM_ADDR_W'(WORD_BYTES - 1);

  rd_state_e             state_q, state_d;
  logic [MEM_ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]      last_idx_q, last_idx_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [MEM_DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]      out_index_q, out_index_d;
  logic                  timer_load;
  logic                  timer_expire;
  logic [MEM_ADDR_W-1:0] word_offset;

  mem_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .en    (state_q == ST_READ),
    .expire(timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    last_idx_d  = last_idx_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    timer_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_addr & ~ALIGN_MASK;
          last_idx_d = word_count - 1'b1;
          idx_d      = '0;
          if (word_count != '0) begin
            state_d    = ST_READ;
            timer_load = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        if (timer_expire) begin
          out_data_d  = mem_read_data;
          out_index_d = idx_q;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        // Output registers hold until the consumer takes the word.
        if (out_ready) begin
          if (idx_q == last_idx_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d      = idx_q + 1'b1;
            state_d    = ST_READ;
            timer_load = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      last_idx_q  <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      last_idx_q  <= last_idx_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  // Address arithmetic wraps modulo 2^32 at the top of the space.
  assign word_offset = MEM_ADDR_W'(idx_q) << $clog2(WORD_BYTES);

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign mem_read  = (state_q == ST_READ);
  assign mem_addr  = (state_q == ST_READ) ? (base_q + word_offset) : '0;
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_mem_region_reader.sv
// Directed bench: table of region commands against a latency-aware memory
// model, plus reset-abort and single-cycle-latency sequences.
module tb_mem_region_reader;
  import mem_bus_pkg::*;

  localparam int W3 = 3;
  localparam int CW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [31:0]   base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done, mem_read, out_valid;
  logic [31:0]   mem_addr, mem_read_data, out_data;
  logic [CW-1:0] out_index;

  logic          start_b = 1'b0;
  logic          out_ready_b = 1'b1;
  logic [31:0]   base_addr_b = '0;
  logic [CW-1:0] word_count_b = '0;
  logic          busy_b, done_b, mem_read_b, out_valid_b;
  logic [31:0]   mem_addr_b, mem_read_data_b, out_data_b;
  logic [CW-1:0] out_index_b;

  logic [31:0] mem [1024];

  mem_region_reader #(.WAIT_CYCLES(W3), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_read_data(mem_read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index)
  );

  mem_region_reader #(.WAIT_CYCLES(1), .CNT_W(CW)) dut_w1 (
    .clk(clk), .reset(reset), .start(start_b), .base_addr(base_addr_b),
    .word_count(word_count_b), .busy(busy_b), .done(done_b), .mem_read(mem_read_b),
    .mem_addr(mem_addr_b), .mem_read_data(mem_read_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_index(out_index_b)
  );

  // Slow memory: data is only valid once read/address have been stable for
  // WAIT_CYCLES cycles; earlier sampling returns a poison word.
  int          hold = 0;
  logic        prev_rd = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (mem_read && prev_rd && (mem_addr == prev_addr)) hold <= hold + 1;
    else hold <= 0;
    prev_rd   <= mem_read;
    prev_addr <= mem_addr;
  end
  assign mem_read_data   = (mem_read && hold >= W3 - 1) ? mem[mem_addr[11:2]] : 32'hDEADBEEF;
  assign mem_read_data_b = mem_read_b ? mem[mem_addr_b[11:2]] : 32'hDEADBEEF;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [9:0]  count;
    int          stall_beat;
    int          stall_len;
    int          restart_cyc;
    int          exp_beats;
    logic [31:0] exp_first_addr;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_first_data;
    logic [31:0] exp_last_data;
    bit          linear;
    int          exp_done_cyc;
  } vec_t;

  // cyc counts edges after the accepting edge; done is expected at cyc N*(W+1).
  task automatic run_vec(input vec_t v);
    logic [31:0]   d_q[$];
    logic [CW-1:0] i_q[$];
    logic [31:0]   a_q[$];
    int cyc = 0;
    int stall_rem = v.stall_len;
    int done_cyc = -1;
    bit got_done = 1'b0;
    bit seen_rd = 1'b0;
    @(negedge clk);
    base_addr = v.base; word_count = v.count; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = 32'h1234_5670; word_count = 10'd7;
    while (!got_done && cyc <= v.exp_done_cyc + 40) begin
      if (mem_read && !seen_rd) a_q.push_back(mem_addr);
      seen_rd = mem_read;
      if (out_valid && int'(d_q.size()) == v.stall_beat && stall_rem > 0) begin
        out_ready = 1'b0;
        stall_rem--;
        check({v.name, ":stall_data"}, out_data, v.exp_first_data + 32'(v.stall_beat));
        check({v.name, ":stall_index"}, 32'(out_index), 32'(v.stall_beat));
        check({v.name, ":stall_mem_read"}, 32'(mem_read), 32'd0);
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        d_q.push_back(out_data);
        i_q.push_back(out_index);
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else begin
        if (cyc == v.restart_cyc) begin
          start = 1'b1; word_count = 10'd1; base_addr = 32'h0;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    check({v.name, ":done_seen"}, 32'(got_done), 32'd1);
    check({v.name, ":done_cycle"}, 32'(done_cyc), 32'(v.exp_done_cyc));
    check({v.name, ":beats"}, 32'(d_q.size()), 32'(v.exp_beats));
    check({v.name, ":reads"}, 32'(a_q.size()), 32'(v.exp_beats));
    for (int i = 0; i < int'(d_q.size()); i++) begin
      check({v.name, ":index"}, 32'(i_q[i]), 32'(i));
      if (v.linear) check({v.name, ":data"}, d_q[i], v.exp_first_data + 32'(i));
    end
    if (!v.linear && d_q.size() > 0) begin
      check({v.name, ":first_data"}, d_q[0], v.exp_first_data);
      check({v.name, ":last_data"}, d_q[d_q.size()-1], v.exp_last_data);
    end
    for (int i = 0; i < int'(a_q.size()); i++)
      check({v.name, ":addr"}, a_q[i], v.exp_first_addr + 32'(4 * i));
    if (a_q.size() > 0)
      check({v.name, ":last_addr"}, a_q[a_q.size()-1], v.exp_last_addr);
    @(negedge clk);
    check({v.name, ":done_pulse_len"}, 32'(done), 32'd0);
    check({v.name, ":idle_after"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[7];
  vec_t fresh;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0FCE + 32'(i);

    vecs[0] = '{"dump",     32'h0000_00C8, 10'd21, -1, 0, -1, 21, 32'h0000_00C8, 32'h0000_0118,
                32'h1000, 32'h1014, 1'b1, 84};
    vecs[1] = '{"backpres", 32'h0000_00C8, 10'd3,   1, 5, -1,  3, 32'h0000_00C8, 32'h0000_00D0,
                32'h1000, 32'h1002, 1'b1, 17};
    vecs[2] = '{"zero",     32'h0000_0040, 10'd0,  -1, 0, -1,  0, 32'h0, 32'h0,
                32'h0, 32'h0, 1'b1, 0};
    vecs[3] = '{"busystart", 32'h0000_00C8, 10'd4, -1, 0,  6,  4, 32'h0000_00C8, 32'h0000_00D4,
                32'h1000, 32'h1003, 1'b1, 16};
    vecs[4] = '{"wrap",     32'hFFFF_FFFE, 10'd2,  -1, 0, -1,  2, 32'hFFFF_FFFC, 32'h0000_0000,
                32'h13CD, 32'h0FCE, 1'b0, 8};
    vecs[5] = '{"unalign",  32'h0000_0103, 10'd3,  -1, 0, -1,  3, 32'h0000_0100, 32'h0000_0108,
                32'h100E, 32'h1010, 1'b1, 12};
    vecs[6] = '{"single",   32'h0000_0000, 10'd1,  -1, 0, -1,  1, 32'h0, 32'h0,
                32'h0FCE, 32'h0FCE, 1'b1, 4};
    fresh   = '{"fresh",    32'h0000_00C8, 10'd2,  -1, 0, -1,  2, 32'h0000_00C8, 32'h0000_00CC,
                32'h1000, 32'h1001, 1'b1, 8};

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:mem_read", 32'(mem_read), 32'd0);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:mem_addr", mem_addr, 32'd0);
    check("rst:out_data", out_data, 32'd0);
    check("rst:out_index", 32'(out_index), 32'd0);
    reset = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Abort while word 2 of 5 is waiting on a stalled consumer.
    begin
      int n = 0;
      int done_seen = 0;
      @(negedge clk);
      base_addr = 32'h0000_00C8; word_count = 10'd5; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (n < 100) begin
        if (out_valid && out_index == 10'd2) break;
        @(negedge clk);
        n++;
      end
      out_ready = 1'b0;
      check("abort:reached_word2", 32'(out_valid && out_index == 10'd2), 32'd1);
      check("abort:word2_data", out_data, 32'h1002);
      reset = 1'b0;
      @(negedge clk);
      check("abort:busy", 32'(busy), 32'd0);
      check("abort:done", 32'(done), 32'd0);
      check("abort:mem_read", 32'(mem_read), 32'd0);
      check("abort:out_valid", 32'(out_valid), 32'd0);
      check("abort:mem_addr", mem_addr, 32'd0);
      check("abort:out_data", out_data, 32'd0);
      check("abort:out_index", 32'(out_index), 32'd0);
      reset = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done) done_seen++;
      end
      check("abort:no_done", 32'(done_seen), 32'd0);
      check("abort:stays_idle", 32'(busy), 32'd0);
      run_vec(fresh);
    end

    // Single-cycle latency build: 4 words in 8 cycles.
    begin
      int cyc = 0;
      int beats = 0;
      int done_cyc = -1;
      @(negedge clk);
      base_addr_b = 32'h0000_00C8; word_count_b = 10'd4; start_b = 1'b1; out_ready_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      while (done_cyc < 0 && cyc < 50) begin
        if (out_valid_b) begin
          check("w1:data", out_data_b, 32'h1000 + 32'(beats));
          check("w1:index", 32'(out_index_b), 32'(beats));
          beats++;
        end
        if (done_b) done_cyc = cyc;
        else begin
          @(negedge clk);
          cyc++;
        end
      end
      check("w1:beats", 32'(beats), 32'd4);
      check("w1:done_cycle", 32'(done_cyc), 32'd8);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_region_reader.md
# mem_region_reader

Initiator-side read engine for the word-addressed asynchronous data memory bus used by the multi-cycle MIPS system. On a start command it walks a contiguous word region (base byte address, word count). For each word it asserts a read, waits a fixed number of cycles for the slow memory data to settle, and captures the word. Each captured word goes out on a valid/ready stream tagged with its index. It is used for result dumps and memory-to-stream transfers alongside the CPU.

## Interface
- WAIT_CYCLES, 3: cycles `mem_read` is held before `mem_read_data` is sampled (memory read latency 7 ns at 2.5 ns clock; must be ≥1)
- CNT_W, 10: width of word count/index (max 1023 words)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low: `reset==0` at a rising edge clears all state
- start  in  1  one-cycle request; accepted only in IDLE
- base_addr  in  32  region start byte address; bits [1:0] ignored (treated as 0)
- word_count  in  CNT_W  number of words to read
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of a command
- mem_read  out  1  memory read enable
- mem_addr  out  32  memory byte address
- mem_read_data  in  32  memory read data, valid WAIT_CYCLES cycles after read/address are stable
- out_valid  out  1  stream word valid
- out_ready  in  1  stream consumer ready
- out_data  out  32  captured word
- out_index  out  CNT_W  word index within region, 0-based

## Operation
- States: IDLE, READ, OUT, DONE.
- Reset values: state IDLE; busy, done, mem_read, out_valid = 0; mem_addr, out_data, out_index = 0; internal counters 0.
- IDLE:
  - `start` with `word_count != 0`: latch `{base_addr[31:2],2'b00}` and count, set idx = 0, go to READ.
  - `start` with `word_count == 0`: go to DONE and issue no memory read.
- READ:
  - mem_read = 1, mem_addr = base + 4*idx (mod 2^32).
  - Wait counter runs 0..WAIT_CYCLES-1.
  - In the cycle where the counter equals WAIT_CYCLES-1, register mem_read_data into out_data and idx into out_index, then go to OUT.
- OUT:
  - mem_read = 0, out_valid = 1.
  - out_data and out_index are held stable until `out_valid && out_ready`.
  - On handshake: if idx == count-1, go to DONE; otherwise idx += 1 and go to READ.
- DONE: done = 1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored and does not queue.
- Base/count inputs are sampled only at accepted start; later changes have no effect.
- mem_addr returns to 0 outside READ.

## Timing
- Start accepted at edge T: mem_read first high in cycle T+1.
- READ lasts exactly WAIT_CYCLES cycles; out_valid rises the cycle after the last READ cycle.
- With out_ready held high, each word takes WAIT_CYCLES+1 cycles. N words take N*(WAIT_CYCLES+1) cycles, and done is high in the cycle after the last handshake.
- Count 0: done is high in cycle T+1; busy is high only in that cycle.
- Backpressure: OUT is held indefinitely, and no new read is issued until the handshake.
- Address wrap: 0xFFFFFFFC + 4 → 0x00000000, with no error.
- Reset low mid-command: next edge forces IDLE with all outputs at reset values. The partial transfer is discarded, and done is not pulsed.
- Reset has priority over start in the same cycle.

## Structure
- Shared package `mem_bus_pkg`:
  - state enum (IDLE/READ/OUT/DONE)
  - `WORD_BYTES = 4`
  - `MEM_ADDR_W = 32`
  - `MEM_DATA_W = 32`
  - default `MEM_WAIT_CYCLES = 3`
- One sub-module, `mem_wait_timer`: loadable down-counter (load WAIT_CYCLES-1, `expire` when 0), instantiated once in READ.

## Test plan
- Basic dump: memory words 50..70 = 0x1000..0x1014, base 0xC8, count 21, out_ready = 1. Expect:
  - 21 beats, data 0x1000..0x1014, index 0..20
  - mem_addr sequence 0xC8..0x118 step 4
  - done exactly 84 cycles after start accept
- Backpressure: count 3, out_ready low for 5 cycles on beat 1. Expect:
  - out_data/out_index stable throughout the stall
  - mem_read low during the stall
  - order preserved
- Zero count and busy start: count 0 gives done next cycle and no mem_read. A second start during a 4-word run is ignored, giving exactly 4 beats.
- Wrap and alignment: base 0xFFFFFFFE, count 2. Expect mem_addr 0xFFFFFFFC then 0x00000000, data from mem[1023] then mem[0].
- Reset mid-operation: reset = 0 while in OUT of word 2 of 5. Expect:
  - all outputs 0 at the next edge
  - no done pulse
  - a fresh start afterwards reads from index 0 correctly
- WAIT_CYCLES = 1 build: 4 words in 8 cycles, every out_data correct.
